fpu_scheduler: RTL and testbench
================================

Name: fpu_scheduler

Overview:
Issue and writeback scheduler for the FPU datapath. It sits between the core's FP issue stage and the execution units (fadd/fsub, fmul, fdiv, fsqrt, itof, ftoi).
- Accepts one FP op per cycle through a valid/ready handshake.
- Issues the op on a shared operand bus to the selected unit.
- Tracks non-pipelined units as busy.
- Reserves slots on the single writeback port so that no two results ever collide.

Parameters:
LAT_FADD, 2, cycles from issue to result valid on unit_res for fadd/fsub (unit 0), pipelined
LAT_FMUL, 2, fmul latency (unit 1), pipelined
LAT_FDIV, 8, fdiv latency (unit 2), non-pipelined
LAT_FSQRT, 8, fsqrt latency (unit 3), non-pipelined
LAT_ITOF, 1, itof latency (unit 4), pipelined
LAT_FTOI, 1, ftoi latency (unit 5), pipelined
TAG_W, 6, destination register tag width
Constraint on all LAT_* values: 1..15. MAXLAT is derived as the maximum of them.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  core presents an op
req_ready  out  1  scheduler accepts this cycle
req_op  in  3  0 fadd, 1 fsub, 2 fmul, 3 fdiv, 4 fsqrt, 5 itof, 6 ftoi, 7 illegal
req_rd  in  TAG_W  destination tag
req_x  in  32  operand x
req_y  in  32  operand y
iss_valid  out  6  one-hot unit strobe (bit = unit index)
iss_sub  out  1  subtract select for unit 0
iss_x  out  32  shared operand x
iss_y  out  32  shared operand y
unit_res  in  192  packed results, unit k at [32k+31:32k]
wb_valid  out  1  result valid
wb_rd  out  TAG_W  result tag
wb_data  out  32  result data
err_illegal  out  1  one-cycle pulse when an illegal op is accepted

Behaviour:
- Unit mapping:
  - op0/1 → unit 0.
  - op2..6 → units 1..5.
  - L(u) = LAT of unit u.
- Accept:
  - acc = req_valid & req_ready in cycle t.
  - iss_valid, iss_x, iss_y and iss_sub are combinational from req_* when acc, else iss_valid=0.
  - iss_x and iss_y are don't-care when iss_valid is 0.
- req_ready = 1 when the op is legal, the unit is not busy, and writeback slot t+L(u) is unreserved.
  - req_ready is 1 unconditionally for op 7.
  - req_ready may depend on req_op. Requesters must hold req_* stable while req_valid=1 and not accepted.
- Illegal op (7):
  - Accepted and dropped; no issue, no reservation.
  - err_illegal=1 in cycle t+1.
- Reservation register rsv[1..MAXLAT], each entry {valid, unit[2:0], rd}, meaning "unit result appears on unit_res k cycles from now".
  - Every cycle: rsv[k] ← rsv[k+1], and rsv[MAXLAT] ← empty.
  - On acc, the entry for the new op is written into the position that will reach k=0 at cycle t+L(u).
- Writeback:
  - In cycle t+L(u), unit_res[u] is valid and the scheduler samples it.
  - wb_valid, wb_rd and wb_data are registered and asserted exactly in cycle t+L(u)+1 for one cycle.
  - At most one wb per cycle is guaranteed by construction.
- Busy:
  - Units 2 and 3 each have a down-counter loaded with L(u)-1 on acc.
  - The unit is busy while the counter ≠ 0, i.e. cycles t+1..t+L(u)-1.
  - Next accept to that unit is at t+L(u) at the earliest.
- Pipelined units accept every cycle, subject only to writeback conflict.
- Ordering: results may return out of program order. Tags identify them; no reorder is performed.
- Simultaneous events:
  - Accept, shift and writeback in the same cycle are all legal.
  - A slot freed by shift-out in cycle t is reusable only by a request whose target cycle is that slot. With a strictly shifting register there is no aliasing.
- Reset (rst=1 at an edge):
  - wb_valid=0, wb_rd=0, wb_data=0, err_illegal=0.
  - All rsv entries invalid, busy counters 0.
  - req_ready is low during reset cycles.
  - In-flight results are discarded: no wb_valid for ops accepted before reset, even if the unit later drives unit_res.
- Illegal parameter values (outside 1..15): elaboration error via assertion.

Test Plan:
1. After reset: itof req_x=1, rd=5 accepted at t; unit_res[4]=0x3F800000 at t+1 → wb_valid=1, wb_rd=5, wb_data=0x3F800000 at t+2 only.
2. fadd rd=1 at t, itof rd=2 requested at t+1 → req_ready=0 at t+1; itof accepted at t+2. wb rd=1 at t+3, rd=2 at t+4, no cycle with a double writeback.
3. fmul stream with req_valid high for 10 cycles, rd=0..9 → req_ready=1 every cycle. wb_rd=0..9 on consecutive cycles starting 3 cycles after the first accept.
4. fdiv at t, second fdiv held valid → req_ready=0 for t+1..t+7, accepted at t+8. An fadd offered at t+3 is accepted immediately.
5. req_op=7 → req_ready=1, err_illegal pulse at t+1, iss_valid=0, no wb ever.
6. fdiv accepted at t, rst=1 at t+3 for 1 cycle → req_ready=0 during reset, no wb_valid through t+12 even with unit_res[2] driven; a new fdiv is accepted at t+4.

Source files
------------

// File: rtl/fpu_scheduler.sv
// FP issue/writeback scheduler: issues one op per cycle on a shared operand bus and
// reserves writeback slots so unit results never collide on the single writeback port.
module fpu_scheduler #(
    parameter int unsigned LAT_FADD  = 2,
    parameter int unsigned LAT_FMUL  = 2,
    parameter int unsigned LAT_FDIV  = 8,
    parameter int unsigned LAT_FSQRT = 8,
    parameter int unsigned LAT_ITOF  = 1,
    parameter int unsigned LAT_FTOI  = 1,
    parameter int unsigned TAG_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [TAG_W-1:0] req_rd,
    input  logic [31:0]      req_x,
    input  logic [31:0]      req_y,
    output logic [5:0]       iss_valid,
    output logic             iss_sub,
    output logic [31:0]      iss_x,
    output logic [31:0]      iss_y,
    input  logic [191:0]     unit_res,
    output logic             wb_valid,
    output logic [TAG_W-1:0] wb_rd,
    output logic [31:0]      wb_data,
    output logic             err_illegal
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAXLAT = max2(max2(max2(LAT_FADD, LAT_FMUL),
                                               max2(LAT_FDIV, LAT_FSQRT)),
                                          max2(LAT_ITOF, LAT_FTOI));

    if (LAT_FADD < 1 || LAT_FADD > 15 || LAT_FMUL < 1 || LAT_FMUL > 15 ||
        LAT_FDIV < 1 || LAT_FDIV > 15 || LAT_FSQRT < 1 || LAT_FSQRT > 15 ||
        LAT_ITOF < 1 || LAT_ITOF > 15 || LAT_FTOI < 1 || LAT_FTOI > 15) begin : g_bad_lat
        $error("fpu_scheduler: every LAT_* parameter must lie in 1..15");
    end

    function automatic logic [3:0] lat_of(input logic [2:0] u);
        case (u)
            3'd0:    return 4'(LAT_FADD);
            3'd1:    return 4'(LAT_FMUL);
            3'd2:    return 4'(LAT_FDIV);
            3'd3:    return 4'(LAT_FSQRT);
            3'd4:    return 4'(LAT_ITOF);
            3'd5:    return 4'(LAT_FTOI);
            default: return 4'd1;
        endcase
    endfunction

    typedef struct packed {
        logic             valid;
        logic [2:0]       unit;
        logic [TAG_W-1:0] rd;
    } rsv_t;

    // rsv_q[j] holds the op whose result is on unit_res j cycles from now
    rsv_t        rsv_q [MAXLAT];
    rsv_t        rsv_d [MAXLAT];
    logic [3:0]  div_cnt_q, div_cnt_d;
    logic [3:0]  sqrt_cnt_q, sqrt_cnt_d;
    logic [2:0]  unit_sel;
    logic [3:0]  lat;
    logic        legal, busy, slot_taken, acc, issue;
    logic [31:0] res_sel;

    always_comb begin
        legal    = (req_op != 3'd7);
        unit_sel = (req_op == 3'd0) ? 3'd0 : req_op - 3'd1;
        lat      = lat_of(unit_sel);
        busy     = ((unit_sel == 3'd2) && (div_cnt_q != 4'd0)) ||
                   ((unit_sel == 3'd3) && (sqrt_cnt_q != 4'd0));
        slot_taken = 1'b0;
        for (int j = 0; j < int'(MAXLAT); j++) begin
            if (int'(lat) == j) slot_taken = rsv_q[j].valid;
        end
        req_ready = !rst && (!legal || (!busy && !slot_taken));
        acc       = req_valid && req_ready;
        issue     = acc && legal;
        iss_valid = issue ? (6'b000001 << unit_sel) : 6'b000000;
        iss_sub   = issue && (req_op == 3'd1);
        iss_x     = req_x;
        iss_y     = req_y;
    end

    always_comb begin
        for (int j = 0; j < int'(MAXLAT) - 1; j++) rsv_d[j] = rsv_q[j+1];
        rsv_d[MAXLAT-1] = '0;
        // Written after the shift, so index lat-1 lands on k=0 exactly at t+lat
        if (issue) begin
            for (int j = 0; j < int'(MAXLAT); j++) begin
                if (int'(lat) - 1 == j) rsv_d[j] = {1'b1, unit_sel, req_rd};
            end
        end

        res_sel = '0;
        for (int u = 0; u < 6; u++) begin
            if (rsv_q[0].unit == 3'(u)) res_sel = unit_res[32*u +: 32];
        end

        div_cnt_d  = (div_cnt_q != 4'd0) ? div_cnt_q - 4'd1 : 4'd0;
        sqrt_cnt_d = (sqrt_cnt_q != 4'd0) ? sqrt_cnt_q - 4'd1 : 4'd0;
        if (issue && unit_sel == 3'd2) div_cnt_d = 4'(LAT_FDIV - 1);
        if (issue && unit_sel == 3'd3) sqrt_cnt_d = 4'(LAT_FSQRT - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < int'(MAXLAT); j++) rsv_q[j] <= '0;
            div_cnt_q   <= 4'd0;
            sqrt_cnt_q  <= 4'd0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            err_illegal <= 1'b0;
        end else begin
            for (int j = 0; j < int'(MAXLAT); j++) rsv_q[j] <= rsv_d[j];
            div_cnt_q   <= div_cnt_d;
            sqrt_cnt_q  <= sqrt_cnt_d;
            wb_valid    <= rsv_q[0].valid;
            if (rsv_q[0].valid) begin
                wb_rd   <= rsv_q[0].rd;
                wb_data <= res_sel;
            end
            err_illegal <= acc && !legal;
        end
    end

endmodule

// File: tb/tb_fpu_scheduler.sv
// Directed table-driven bench for fpu_scheduler; unit k drives {0xC0+k, 0x00, cycle[15:0]}
// so each writeback's data also pins down the cycle in which it was sampled.
module tb_fpu_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [5:0]   req_rd;
    logic [31:0]  req_x;
    logic [31:0]  req_y;
    logic [5:0]   iss_valid;
    logic         iss_sub;
    logic [31:0]  iss_x;
    logic [31:0]  iss_y;
    logic [191:0] unit_res;
    logic         wb_valid;
    logic [5:0]   wb_rd;
    logic [31:0]  wb_data;
    logic         err_illegal;

    int unsigned cyc = 0;
    logic        ovr = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int u = 0; u < 6; u++) unit_res[32*u +: 32] = {8'(8'hC0 + u), 8'h00, cyc[15:0]};
        if (ovr) unit_res[159:128] = 32'h3F800000;
    end

    fpu_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rd     (req_rd),
        .req_x      (req_x),
        .req_y      (req_y),
        .iss_valid  (iss_valid),
        .iss_sub    (iss_sub),
        .iss_x      (iss_x),
        .iss_y      (iss_y),
        .unit_res   (unit_res),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .err_illegal(err_illegal)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [2:0] op;
        logic [5:0] rd;
        logic       rdy;
        logic [5:0] iss;
        logic       sub;
        logic       wbv;
        logic [5:0] wbrd;
        logic [2:0] wbu;
        logic       err;
    } row_t;

    row_t vec[$];

    function automatic row_t mk(logic r, logic v, logic [2:0] op, logic [5:0] rd, logic rdy,
                                logic [5:0] iss, logic wbv, logic [5:0] wbrd, logic [2:0] wbu,
                                logic err);
        row_t x;
        x.rst = r; x.vld = v; x.op = op; x.rd = rd; x.rdy = rdy; x.iss = iss;
        x.sub = iss[0] && (op == 3'd1);
        x.wbv = wbv; x.wbrd = wbrd; x.wbu = wbu; x.err = err;
        return x;
    endfunction

    // Idle cycles offer op 7 with valid low, so ready is 1 and nothing is accepted
    function automatic row_t idle(logic wbv, logic [5:0] wbrd, logic [2:0] wbu);
        return mk(1'b0, 1'b0, 3'd7, 6'd0, 1'b1, 6'd0, wbv, wbrd, wbu, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // fadd then itof colliding on the same writeback slot
        vec.push_back(mk(0, 1, 3'd0, 6'd1, 1, 6'b000001, 0, 0, 0, 0));
        vec.push_back(mk(0, 1, 3'd5, 6'd2, 0, 6'b000000, 0, 0, 0, 0));
        vec.push_back(mk(0, 1, 3'd5, 6'd2, 1, 6'b010000, 0, 0, 0, 0));
        vec.push_back(idle(1, 6'd1, 3'd0));
        vec.push_back(idle(1, 6'd2, 3'd4));
        vec.push_back(idle(0, 0, 0));
        // back-to-back fmul stream
        for (int k = 0; k < 10; k++)
            vec.push_back(mk(0, 1, 3'd2, 6'(k), 1, 6'b000010, k >= 3, 6'(k - 3), 3'd1, 0));
        for (int k = 7; k < 10; k++) vec.push_back(idle(1, 6'(k), 3'd1));
        vec.push_back(idle(0, 0, 0));
        // fdiv busy window, with an fadd slipped in at t+3
        vec.push_back(mk(0, 1, 3'd3, 6'd10, 1, 6'b000100, 0, 0, 0, 0));
        vec.push_back(mk(0, 1, 3'd3, 6'd11, 0, 6'b000000, 0, 0, 0, 0));
        vec.push_back(mk(0, 1, 3'd3, 6'd11, 0, 6'b000000, 0, 0, 0, 0));
        vec.push_back(mk(0, 1, 3'd0, 6'd12, 1, 6'b000001, 0, 0, 0, 0));
        vec.push_back(mk(0, 1, 3'd3, 6'd11, 0, 6'b000000, 0, 0, 0, 0));
        vec.push_back(mk(0, 1, 3'd3, 6'd11, 0, 6'b000000, 0, 0, 0, 0));
        vec.push_back(mk(0, 1, 3'd3, 6'd11, 0, 6'b000000, 1, 6'd12, 3'd0, 0));
        vec.push_back(mk(0, 1, 3'd3, 6'd11, 0, 6'b000000, 0, 0, 0, 0));
        vec.push_back(mk(0, 1, 3'd3, 6'd11, 1, 6'b000100, 0, 0, 0, 0));
        vec.push_back(idle(1, 6'd10, 3'd2));
        for (int k = 0; k < 7; k++) vec.push_back(idle(0, 0, 0));
        vec.push_back(idle(1, 6'd11, 3'd2));
        vec.push_back(idle(0, 0, 0));
        // illegal op
        vec.push_back(mk(0, 1, 3'd7, 6'd7, 1, 6'b000000, 0, 0, 0, 0));
        vec.push_back(mk(0, 0, 3'd7, 6'd0, 1, 6'b000000, 0, 0, 0, 1));
        vec.push_back(idle(0, 0, 0));
        // reset with an fdiv in flight
        vec.push_back(mk(0, 1, 3'd3, 6'd20, 1, 6'b000100, 0, 0, 0, 0));
        vec.push_back(idle(0, 0, 0));
        vec.push_back(idle(0, 0, 0));
        vec.push_back(mk(1, 1, 3'd3, 6'd21, 0, 6'b000000, 0, 0, 0, 0));
        vec.push_back(mk(0, 1, 3'd3, 6'd21, 1, 6'b000100, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++) vec.push_back(idle(0, 0, 0));
        vec.push_back(idle(1, 6'd21, 3'd2));
        vec.push_back(idle(0, 0, 0));
        // fsub, ftoi, fsqrt busy
        vec.push_back(mk(0, 1, 3'd1, 6'd3, 1, 6'b000001, 0, 0, 0, 0));
        vec.push_back(idle(0, 0, 0));
        vec.push_back(idle(0, 0, 0));
        vec.push_back(idle(1, 6'd3, 3'd0));
        vec.push_back(mk(0, 1, 3'd6, 6'd4, 1, 6'b100000, 0, 0, 0, 0));
        vec.push_back(idle(0, 0, 0));
        vec.push_back(idle(1, 6'd4, 3'd5));
        vec.push_back(mk(0, 1, 3'd4, 6'd9, 1, 6'b001000, 0, 0, 0, 0));
        vec.push_back(mk(0, 1, 3'd4, 6'd8, 0, 6'b000000, 0, 0, 0, 0));
        for (int k = 0; k < 7; k++) vec.push_back(idle(0, 0, 0));
        vec.push_back(idle(1, 6'd9, 3'd3));
        vec.push_back(idle(0, 0, 0));

        rst = 1'b1; req_valid = 1'b0; req_op = 3'd7; req_rd = '0; req_x = '0; req_y = '0;
        repeat (2) next_cycle();
        @(negedge clk);
        chk("reset ready", 32'(req_ready), 32'd0);
        chk("reset wb_valid", 32'(wb_valid), 32'd0);
        chk("reset wb_rd", 32'(wb_rd), 32'd0);
        chk("reset wb_data", wb_data, 32'd0);
        chk("reset err", 32'(err_illegal), 32'd0);

        // itof with a specific result value
        next_cycle();
        rst = 1'b0; req_valid = 1'b1; req_op = 3'd5; req_rd = 6'd5; req_x = 32'd1;
        @(negedge clk);
        chk("itof ready", 32'(req_ready), 32'd1);
        chk("itof iss_valid", 32'(iss_valid), 32'h10);
        chk("itof iss_x", iss_x, 32'd1);
        next_cycle();
        req_valid = 1'b0; req_op = 3'd7; ovr = 1'b1;
        @(negedge clk);
        chk("itof t+1 wb_valid", 32'(wb_valid), 32'd0);
        next_cycle();
        ovr = 1'b0;
        @(negedge clk);
        chk("itof t+2 wb_valid", 32'(wb_valid), 32'd1);
        chk("itof t+2 wb_rd", 32'(wb_rd), 32'd5);
        chk("itof t+2 wb_data", wb_data, 32'h3F800000);
        next_cycle();
        @(negedge clk);
        chk("itof t+3 wb_valid", 32'(wb_valid), 32'd0);

        for (int i = 0; i < vec.size(); i++) begin
            next_cycle();
            rst       = vec[i].rst;
            req_valid = vec[i].vld;
            req_op    = vec[i].op;
            req_rd    = vec[i].rd;
            req_x     = 32'h1000 + 32'(vec[i].rd);
            req_y     = 32'h2000 + 32'(vec[i].rd);
            @(negedge clk);
            chk($sformatf("row%0d ready", i), 32'(req_ready), 32'(vec[i].rdy));
            chk($sformatf("row%0d iss_valid", i), 32'(iss_valid), 32'(vec[i].iss));
            chk($sformatf("row%0d err", i), 32'(err_illegal), 32'(vec[i].err));
            chk($sformatf("row%0d wb_valid", i), 32'(wb_valid), 32'(vec[i].wbv));
            if (vec[i].iss != 6'd0) begin
                chk($sformatf("row%0d iss_sub", i), 32'(iss_sub), 32'(vec[i].sub));
                chk($sformatf("row%0d iss_x", i), iss_x, 32'h1000 + 32'(vec[i].rd));
                chk($sformatf("row%0d iss_y", i), iss_y, 32'h2000 + 32'(vec[i].rd));
            end
            if (vec[i].wbv) begin
                chk($sformatf("row%0d wb_rd", i), 32'(wb_rd), 32'(vec[i].wbrd));
                chk($sformatf("row%0d wb_data", i), wb_data,
                    {8'(8'hC0 + vec[i].wbu), 8'h00, 16'(cyc - 1)});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
